// File: rtl/wb_write_queue.sv
// Writeback queue: merges up to two results per cycle into an in-order FIFO that drains one
// registered write per cycle into the register bank. Define WB_BYPASS_EN for pending-write lookup.
module wb_write_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTRW  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic [4:0]  qaddr1,
    input  logic [4:0]  qaddr2,
    output logic        qhit1,
    output logic [31:0] qdata1,
    output logic        qhit2,
    output logic [31:0] qdata2,
    output logic [4:0]  AW,
    output logic [31:0] Datow,
    output logic        Wen,
    output logic        stall,
    output logic        ovf
);
    localparam int unsigned CW = PTRW + 1;
    localparam logic [CW-1:0] DepthW = CW'(DEPTH);

    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [4:0]       aw_q, aw_d;
    logic [31:0]      datow_q, datow_d;
    logic             wen_q, wen_d;
    logic             ovf_q, ovf_d;

    logic             mem_req, alu_req;
    logic             mem_acc, alu_acc;
    logic             pop;
    logic [CW-1:0]    free_slots;
    logic [CW-1:0]    n_push;
    logic [PTRW-1:0]  alu_slot;

    // Admission: mem is older and claims a free slot before the ALU result does.
    always_comb begin
        free_slots = DepthW - count_q;
        mem_req    = mem_valid && (mem_addr != 5'd0);
        alu_req    = alu_valid && (alu_addr != 5'd0);
        mem_acc    = mem_req && (free_slots != '0);
        alu_acc    = alu_req && (free_slots > CW'(mem_acc));
        n_push     = CW'(mem_acc) + CW'(alu_acc);
        alu_slot   = wr_ptr_q + PTRW'(mem_acc);
        pop        = (count_q != '0);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + n_push[PTRW-1:0];
        rd_ptr_d = rd_ptr_q + PTRW'(pop);
        count_d  = count_q + n_push - CW'(pop);
        ovf_d    = ovf_q | (mem_req & ~mem_acc) | (alu_req & ~alu_acc);

        aw_d     = aw_q;
        datow_d  = datow_q;
        wen_d    = pop;
        if (pop) begin
            aw_d    = addr_q[rd_ptr_q];
            datow_d = data_q[rd_ptr_q];
        end

        // Pop slot and push slots never coincide: a push needs count < DEPTH, a pop count > 0.
        vld_d = vld_q;
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (mem_acc) begin
            vld_d[wr_ptr_q] = 1'b1;
        end
        if (alu_acc) begin
            vld_d[alu_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            aw_q     <= '0;
            datow_q  <= '0;
            wen_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            aw_q     <= aw_d;
            datow_q  <= datow_d;
            wen_q    <= wen_d;
            ovf_q    <= ovf_d;
        end
    end

    // Payload storage needs no reset; the valid bits and count qualify it.
    always_ff @(posedge clk) begin
        if (mem_acc) begin
            addr_q[wr_ptr_q] <= mem_addr;
            data_q[wr_ptr_q] <= mem_data;
        end
        if (alu_acc) begin
            addr_q[alu_slot] <= alu_addr;
            data_q[alu_slot] <= alu_data;
        end
    end

`ifdef WB_BYPASS_EN
    logic [PTRW-1:0] scan_idx;
    logic            hit1, hit2;
    logic [31:0]     dat1, dat2;

    // Scan oldest to youngest so the youngest match overrides; the output register is oldest.
    always_comb begin
        hit1     = 1'b0;
        dat1     = '0;
        hit2     = 1'b0;
        dat2     = '0;
        scan_idx = rd_ptr_q;
        if (wen_q && (aw_q == qaddr1)) begin
            hit1 = 1'b1;
            dat1 = datow_q;
        end
        if (wen_q && (aw_q == qaddr2)) begin
            hit2 = 1'b1;
            dat2 = datow_q;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr_q + PTRW'(k);
            if (vld_q[scan_idx] && (addr_q[scan_idx] == qaddr1)) begin
                hit1 = 1'b1;
                dat1 = data_q[scan_idx];
            end
            if (vld_q[scan_idx] && (addr_q[scan_idx] == qaddr2)) begin
                hit2 = 1'b1;
                dat2 = data_q[scan_idx];
            end
        end
        if (qaddr1 == 5'd0) begin
            hit1 = 1'b0;
            dat1 = '0;
        end
        if (qaddr2 == 5'd0) begin
            hit2 = 1'b0;
            dat2 = '0;
        end
    end

    assign qhit1  = hit1;
    assign qdata1 = dat1;
    assign qhit2  = hit2;
    assign qdata2 = dat2;
`else
    logic unused_bypass;
    assign unused_bypass = ^{qaddr1, qaddr2, vld_q};

    assign qhit1  = 1'b0;
    assign qdata1 = '0;
    assign qhit2  = 1'b0;
    assign qdata2 = '0;
`endif

    assign AW    = aw_q;
    assign Datow = datow_q;
    assign Wen   = wen_q;
    assign ovf   = ovf_q;
    assign stall = (free_slots < CW'(2));

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: stimulus queues expected bank writes, a negedge monitor
// pops and compares every Wen pulse; directed checks cover latency, stall, ovf, reset and bypass.
module tb_wb_write_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic [4:0]  qaddr1 = '0;
    logic [4:0]  qaddr2 = '0;
    logic        qhit1, qhit2;
    logic [31:0] qdata1, qdata2;
    logic [4:0]  AW;
    logic [31:0] Datow;
    logic        Wen, stall, ovf;

    int n_cmp = 0;
    int n_fail = 0;
    int wr_count = 0;
    logic [36:0] exp_q [$];

    wb_write_queue #(.DEPTH(4), .PTRW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .qaddr1(qaddr1), .qaddr2(qaddr2),
        .qhit1(qhit1), .qdata1(qdata1), .qhit2(qhit2), .qdata2(qdata2),
        .AW(AW), .Datow(Datow), .Wen(Wen), .stall(stall), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                          input logic av, input logic [4:0] aa, input logic [31:0] ad);
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
        step();
    endtask

    // Monitor: every bank write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (Wen === 1'b1) begin
            logic [36:0] e;
            wr_count++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got AW=%0d Datow=%h, expected no write", AW, Datow);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {27'd0, AW}, {27'd0, e[36:32]});
                check("wr_data", Datow, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int wr_base;
        idle();
        step();
        step();
        rst_n = 1'b1;
        check("rst_wen", Wen, 0);
        check("rst_aw", AW, 0);
        check("rst_datow", Datow, 0);
        check("rst_ovf", ovf, 0);
        check("rst_stall", stall, 0);

        // Single ALU result: one write, one cycle after the push edge.
        expect_wr(5'd5, 32'h0000_000A);
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_000A);
        step();
        idle();
        check("t1_wen_before", Wen, 0);
        check("t1_stall0", stall, 0);
        step();
        check("t1_wen", Wen, 1);
        check("t1_aw", AW, 5);
        check("t1_datow", Datow, 32'hA);
        check("t1_stall1", stall, 0);
        step();
        check("t1_wen_off", Wen, 0);
        check("t1_stall2", stall, 0);

        // Dual push: mem result drains first.
        expect_wr(5'd8, 32'd25);
        expect_wr(5'd9, 32'd30);
        set_in(1'b1, 5'd8, 32'd25, 1'b1, 5'd9, 32'd30);
        step();
        idle();
        step();
        check("t2_wen_a", Wen, 1);
        check("t2_aw_a", AW, 8);
        step();
        check("t2_wen_b", Wen, 1);
        check("t2_aw_b", AW, 9);
        check("t2_datow_b", Datow, 32'd30);
        step();
        check("t2_wen_off", Wen, 0);

        // Address-zero result is filtered.
        expect_wr(5'd26, 32'd1);
        set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd26, 32'd1);
        step();
        idle();
        step();
        check("t3_wen", Wen, 1);
        check("t3_aw", AW, 26);
        step();
        check("t3_wen_off", Wen, 0);
        step();

        // Overflow: both producers for 4 edges ignoring stall; ALU drops on edges 3 and 4.
        wr_base = wr_count;
        expect_wr(5'd10, 32'd100);
        expect_wr(5'd20, 32'd200);
        expect_wr(5'd11, 32'd101);
        expect_wr(5'd21, 32'd201);
        expect_wr(5'd12, 32'd102);
        expect_wr(5'd13, 32'd103);
        for (int c = 0; c < 4; c++) begin
            set_in(1'b1, 5'(10 + c), 32'(100 + c), 1'b1, 5'(20 + c), 32'(200 + c));
            step();
            check($sformatf("ovf_stall_%0d", c), stall, (c >= 1) ? 1 : 0);
            check($sformatf("ovf_flag_%0d", c), ovf, (c >= 2) ? 1 : 0);
        end
        idle();
        wait_drain(20);
        step();
        check("ovf_wr_total", wr_count - wr_base, 6);
        check("ovf_sticky", ovf, 1);
        check("ovf_stall_idle", stall, 0);

        // Reset with three entries queued discards them all.
        expect_wr(5'd3, 32'd33);
        set_in(1'b1, 5'd3, 32'd33, 1'b1, 5'd4, 32'd44);
        step();
        set_in(1'b1, 5'd6, 32'd66, 1'b1, 5'd7, 32'd77);
        step();
        idle();
        check("mid_stall", stall, 1);
        check("mid_ovf_held", ovf, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_wen", Wen, 0);
        check("mid_rst_aw", AW, 0);
        check("mid_rst_datow", Datow, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_stall", stall, 0);
        repeat (8) step();
        check("mid_rst_pending", exp_q.size(), 0);

        // Bypass lookup on two pending writes to r12.
        qaddr1 = 5'd12;
        qaddr2 = 5'd0;
        expect_wr(5'd12, 32'd45);
        expect_wr(5'd12, 32'd50);
        set_in(1'b1, 5'd12, 32'd45, 1'b1, 5'd12, 32'd50);
        #1;
        check("byp_same_cycle_hit", qhit1, 0);
        step();
        idle();
        for (int c = 0; c < 4; c++) begin
`ifdef WB_BYPASS_EN
            check($sformatf("byp_hit1_%0d", c), qhit1, (c < 3) ? 1 : 0);
            if (c < 3) check($sformatf("byp_data1_%0d", c), qdata1, 32'd50);
`else
            check($sformatf("byp_hit1_%0d", c), qhit1, 0);
            check($sformatf("byp_data1_%0d", c), qdata1, 0);
`endif
            check($sformatf("byp_hit2_%0d", c), qhit2, 0);
            step();
        end
        wait_drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Writeback queue that feeds the single write port (AW/Datow/Wen) of the 32x32 register bank.
- Accepts up to two results per cycle from the memory stage and the ALU stage, and buffers them in an in-order FIFO.
- Drains one write per cycle into the bank.
- Raises stall when it cannot guarantee space for two more results.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 4.
- PTRW, 2, pointer width = log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- mem_valid  input  1  memory-stage result present
- mem_addr  input  5  destination register of memory result
- mem_data  input  32  memory result
- alu_valid  input  1  ALU result present
- alu_addr  input  5  destination register of ALU result
- alu_data  input  32  ALU result
- qaddr1  input  5  bypass lookup address, read port 1 (mirrors AR1)
- qaddr2  input  5  bypass lookup address, read port 2 (mirrors AR2)
- qhit1  output  1  a pending write to qaddr1 exists
- qdata1  output  32  youngest pending data for qaddr1
- qhit2  output  1  a pending write to qaddr2 exists
- qdata2  output  32  youngest pending data for qaddr2
- AW  output  5  bank write address, registered
- Datow  output  32  bank write data, registered
- Wen  output  1  bank write enable, registered
- stall  output  1  upstream must not present results this cycle
- ovf  output  1  sticky overflow flag

Behaviour:
- Reset is synchronous and active-low. When rst_n=0 at a rising edge:
  - wr_ptr, rd_ptr and count are set to 0, and all entry valid bits are cleared.
  - AW=0, Datow=0, Wen=0, ovf=0.
  - stall=0, since it is derived from count=0.
- Reset mid-operation discards every queued entry. No bank write is issued for discarded entries.
- Push filtering:
  - A result with addr==0 is discarded and never queued; $zero is never written.
  - A result with valid=0 is ignored.
- Push order within a cycle: the mem result goes in first because it is the older instruction, then the ALU result.
  - 0, 1 or 2 pushes per edge.
  - wr_ptr advances by the number of pushes, modulo DEPTH.
- Pop: at each edge where count>0 (count sampled before this edge's pushes):
  - The head entry is loaded into AW/Datow, Wen<=1, and rd_ptr advances modulo DEPTH.
  - If count==0, Wen<=0. AW and Datow hold their last values.
- Simultaneous push and pop: count_next = count + pushes - pop. Entries pushed this edge are not eligible to pop this edge.
- Latency: a result pushed into an empty queue at edge t drives Wen=1 from edge t+1 to t+2. The bank captures the write during that cycle.
- Ordering: bank writes occur in strict push order. Two writes to the same register both issue, and the younger one lands last.
- stall is combinational: stall = (DEPTH - count) < 2.
- Overflow: if the producers present more non-zero-address results than there are free slots, the excess is dropped (ALU first, then mem) and ovf is set.
  - ovf stays set until reset.
  - Accepted entries are unaffected.
- Full boundary: at count==DEPTH, pushes are dropped as above, and the pop still proceeds.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined — matching:
  - qhitN=1 when qaddrN!=0 and qaddrN matches any valid queued entry, or matches AW while Wen=1.
  - Only entries already in the queue or in the output register are searched. Same-cycle inputs are not searched.
- Defined — priority for qdataN: the youngest matching queued entry (nearest to wr_ptr-1) wins, then the output register.
- Defined — timing: the lookup is combinational.
- Not defined: qhit1=qhit2=0, qdata1=qdata2=0, and no comparison logic is generated.

Test Plan:
- Reset, then alu_valid=1, alu_addr=5, alu_data=0x0000000A for one cycle -> next edge Wen=1, AW=5, Datow=0x0A for exactly one cycle; count returns to 0; stall=0 throughout.
- Same cycle: mem (addr 8, data 25) and alu (addr 9, data 30) -> Wen high on two consecutive cycles: first AW=8/Datow=25, then AW=9/Datow=30.
- mem_addr=0 with data 0xFFFFFFFF plus alu_addr=26 with data 1 -> only one write (AW=26, Datow=1); no write to address 0.
- Hold both valids with distinct addresses, ignoring stall, for 4 cycles with DEPTH=4:
  - stall=1 once count reaches 3.
  - ovf=1 after the first drop and stays set.
  - Every accepted entry drains in order; the total write count equals the accepted count.
- With WB_BYPASS_EN: queue writes to reg 12 with data 45 then 50, set qaddr1=12 and qaddr2=0 -> qhit1=1 and qdata1=50 until the data-50 entry has drained, then qhit1=0; qhit2=0 at all times.
- Mid-operation: with 3 entries queued, drive rst_n=0 for one edge -> Wen=0, AW=0, Datow=0, ovf=0, and no further writes follow.
